async_to_sync_bridge: RTL and testbench

Converts a 4-phase return-to-zero bundled-data channel into a clocked valid/ready stream. The channel is driven by a self-timed C-element pipeline, and the bridge sits directly downstream of it. The bridge synchronizes the incoming request, captures the bundled data into a small FIFO and generates the acknowledge. The FIFO then drains into the synchronous output logic of the tile.

---
 rtl/async_to_sync_bridge.sv | 104 ++++++++++
 tb/tb_async_to_sync_bridge.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/async_to_sync_bridge.sv
// rtl/async_to_sync_bridge.sv - 4-phase bundled-data to valid/ready bridge
// Request synchronizer, handshake FSM and first-word fall-through FIFO.
module async_to_sync_bridge #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             stall,
    output logic [7:0]       xfer_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACKED = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [0:0]             r_state;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW:0]            r_count;
    logic [7:0]             r_xfer;

    logic w_req_s;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_req_s = r_sync[SYNC_STAGES-1];
    assign w_full  = (r_count == FULL_COUNT);
    // Push eligibility uses the registered count, so a same-edge pop cannot unblock a full FIFO.
    assign w_push  = (r_state == S_IDLE) && w_req_s && !w_full;
    assign w_pop   = out_valid && out_ready;

    assign a_ack      = (r_state == S_ACKED);
    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign stall      = (r_state == S_IDLE) && w_req_s && w_full;
    assign xfer_count = r_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], a_req};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_xfer   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_state  <= S_ACKED;
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_xfer   <= r_xfer + 8'd1;
                    end
                end
                S_ACKED: begin
                    if (!w_req_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // a_data is bundled with a_req, so it is already stable when the synchronized request pushes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= a_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_async_to_sync_bridge.sv
// tb/tb_async_to_sync_bridge.sv - randomized, model-checked bench for async_to_sync_bridge
module tb_async_to_sync_bridge;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic             clk;
    logic             rst_n;
    logic             a_req;
    logic [WIDTH-1:0] a_data;
    logic             a_ack;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             stall;
    logic [7:0]       xfer_count;

    async_to_sync_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .a_req(a_req), .a_data(a_data), .a_ack(a_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall(stall), .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit rnd_en = 0;
    bit sb_en  = 0;
    logic [7:0] tx[$];
    logic [7:0] rx[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a_req seen through a delay line, a queue for the FIFO, an ack bit.
    bit         hist[SYNC];
    bit         m_ack;
    logic [7:0] m_q[$];
    int         m_xfer;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 0;
            m_ack  = 0;
            m_q.delete();
            m_xfer = 0;
        end else begin
            bit req_s, do_push, do_pop;
            req_s   = hist[SYNC-1];
            do_push = !m_ack && req_s && (m_q.size() < DEPTH);
            do_pop  = (m_q.size() != 0) && (out_ready === 1'b1);
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(a_data);
                m_ack  = 1;
                m_xfer = (m_xfer + 1) % 256;
            end else if (m_ack && !req_s) begin
                m_ack = 0;
            end
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = a_req;
        end
    end

    always @(negedge clk) begin
        chk("a_ack", a_ack, m_ack);
        chk("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
        chk("stall", stall, !m_ack && hist[SYNC-1] && (m_q.size() == DEPTH));
        chk("xfer_count", xfer_count, m_xfer);
        if (rst_n && sb_en && out_valid && out_ready) rx.push_back(out_data);
    end

    task automatic step();
        @(posedge clk);
        #2;
        if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ack(input logic level, input string name);
        int n = 0;
        while (a_ack !== level && n < 200) begin step(); n++; end
        chk(name, a_ack, level);
    endtask

    task automatic handshake(input logic [7:0] d);
        a_data = d;
        a_req  = 1;
        if (sb_en) tx.push_back(d);
        wait_ack(1'b1, "ack_rise_timeout");
        a_req = 0;
        a_data = 8'($urandom);
        wait_ack(1'b0, "ack_fall_timeout");
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        while (out_valid && n < 50) begin step(); n++; end
        chk("drain_empty", out_valid, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();
    endtask

    initial begin
        logic [7:0] exp3[4];
        exp3[0] = 8'h02; exp3[1] = 8'h03; exp3[2] = 8'h04; exp3[3] = 8'h05;
        rst_n = 0; a_req = 0; a_data = 0; out_ready = 0;
        #1;
        chk("rst_a_ack", a_ack, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        step(); step();
        rst_n = 1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_ack", a_ack, 0);
            chk("idle_valid", out_valid, 0);
            chk("idle_stall", stall, 0);
            chk("idle_xfer", xfer_count, 0);
        end

        // Single transfer latency
        out_ready = 1; a_data = 8'hA5; a_req = 1;
        step(); chk("lat_n", a_ack, 0);
        step(); chk("lat_n1", a_ack, 0);
        step(); chk("lat_n2", a_ack, 1);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 8'hA5);
        step(); chk("lat_popped", out_valid, 0);
        a_req = 0;
        step(); chk("fall_m", a_ack, 1);
        step(); chk("fall_m1", a_ack, 1);
        step(); chk("fall_m2", a_ack, 0);
        chk("xfer_one", xfer_count, 1);

        // Fill, stall, unblock one cycle after the pop
        out_ready = 0;
        for (int i = 1; i <= 4; i++) handshake(8'(i));
        a_data = 8'h05; a_req = 1;
        step(); step(); step();
        chk("full_ack", a_ack, 0);
        chk("full_stall", stall, 1);
        chk("full_head", out_data, 8'h01);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("pop_ack", a_ack, 0);
        chk("pop_stall", stall, 0);
        chk("pop_head", out_data, 8'h02);
        step();
        chk("late_push_ack", a_ack, 1);
        a_req = 0;
        wait_ack(1'b0, "ack_fall_timeout");
        for (int i = 0; i < 4; i++) begin
            chk("order_valid", out_valid, 1);
            chk("order_data", out_data, exp3[i]);
            out_ready = 1;
            step();
            out_ready = 0;
        end
        chk("order_empty", out_valid, 0);

        // Reset mid-handshake
        handshake(8'h11);
        a_data = 8'h22; a_req = 1;
        wait_ack(1'b1, "ack_rise_timeout");
        #1 rst_n = 0;
        #1;
        chk("arst_ack", a_ack, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_xfer", xfer_count, 0);
        a_req = 0;
        step(); step();
        rst_n = 1;
        step(); step(); step();
        chk("post_rst_ack", a_ack, 0);
        chk("post_rst_valid", out_valid, 0);
        out_ready = 1; a_data = 8'h3C; a_req = 1;
        wait_ack(1'b1, "ack_rise_timeout");
        chk("post_rst_valid2", out_valid, 1);
        chk("post_rst_data", out_data, 8'h3C);
        a_req = 0;
        wait_ack(1'b0, "ack_fall_timeout");
        chk("post_rst_xfer", xfer_count, 1);

        // Push and pop on the same edge with one entry held
        out_ready = 0;
        handshake(8'h61);
        a_data = 8'h62; a_req = 1;
        step(); step();
        out_ready = 1;
        step();
        out_ready = 0;
        chk("same_edge_ack", a_ack, 1);
        chk("same_edge_valid", out_valid, 1);
        chk("same_edge_data", out_data, 8'h62);
        step();
        chk("same_edge_hold", out_valid, 1);
        chk("same_edge_hold_data", out_data, 8'h62);
        a_req = 0;
        wait_ack(1'b0, "ack_fall_timeout");
        drain();

        // 257 back-to-back transfers, then randomized traffic, scoreboarded
        do_reset();
        sb_en = 1; out_ready = 1;
        for (int i = 0; i < 257; i++) handshake(8'($urandom));
        step();
        chk("wrap_xfer", xfer_count, 1);
        rnd_en = 1;
        for (int i = 0; i < 60; i++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
            handshake(8'($urandom));
        end
        rnd_en = 0;
        drain();
        step();
        sb_en = 0;
        chk("rand_xfer", xfer_count, (257 + 60) % 256);
        chk("sb_count", rx.size(), tx.size());
        for (int i = 0; i < tx.size() && i < rx.size(); i++) begin
            if (rx[i] !== tx[i]) chk("sb_data", rx[i], tx[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
